clk_div_gen: RTL
================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, counter and divisor width (2..16).
REQ-002 SHALL have parameter DIV_INIT, default 128, half-period in clk cycles loaded at reset (1..2^CNT_W-1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable; low freezes all state.
REQ-006 SHALL have port sync  input  1  synchronous restart of the divider phase.
REQ-007 SHALL have port div_load  input  1  one-cycle request to capture div_val.
REQ-008 SHALL have port div_val  input  CNT_W  new half-period N.
REQ-009 SHALL have port clk_out  output  1  divided square wave, period 2*N cycles.
REQ-010 SHALL have port tick  output  1  one-cycle pulse on every clk_out toggle.
REQ-011 SHALL have port rise_tick  output  1  one-cycle pulse on clk_out 0->1 only (symbol strobe).
REQ-012 SHALL have port div_cur  output  CNT_W  half-period currently in use.

Function
REQ-013 SHALL hold active half-period N in register div_cur; div_val of 0 SHALL be stored as 1.
REQ-014 SHALL count 0..N-1 on enabled cycles; at count==N-1 (wrap) count returns to 0 and clk_out toggles.
REQ-015 tick SHALL be registered, high exactly in the cycle clk_out shows its new value; rise_tick likewise when new value is 1.
REQ-016 tick and rise_tick SHALL be 0 in every cycle not following a wrap, including all cycles with en=0.
REQ-017 div_load SHALL capture div_val into a pending register; later load before use overwrites (last wins).
REQ-018 pending value SHALL become div_cur only at the next enabled wrap or at sync; clk_out half-periods are never truncated (glitch-free).
REQ-019 div_load in the same cycle as a wrap SHALL apply its div_val at that wrap.
REQ-020 div_load while en=0 SHALL stay pending until the next enabled wrap or sync.
REQ-021 sync=1 SHALL, next edge: count=0, clk_out=0, tick=0, rise_tick=0, pending value (or simultaneous div_val) into div_cur.
REQ-022 priority SHALL be reset > sync > en; sync acts regardless of en.
REQ-023 en=0 SHALL hold count, clk_out, div_cur and pending state unchanged.
REQ-024 N=1 SHALL give clk_out toggling every enabled cycle with tick high continuously while en=1.

Reset
REQ-025 reset SHALL immediately force count=0, clk_out=0, tick=0, rise_tick=0, div_cur=DIV_INIT, no pending load.
REQ-026 reset asserted mid-period SHALL discard the partial period; first wrap after release occurs after N enabled cycles.

Configuration
REQ-027 macro CLK_DIV_QUAD_EN defined SHALL add output clk_q  1  quadrature copy of clk_out.
REQ-028 with CLK_DIV_QUAD_EN, clk_q SHALL toggle on enabled cycles where count==(N>>1) and N>=2, lagging clk_out by N/2 cycles (90 deg for even N); reset/sync force clk_q=0.
REQ-029 with CLK_DIV_QUAD_EN and N=1, clk_q SHALL equal clk_out.
REQ-030 without CLK_DIV_QUAD_EN, port clk_q and its logic SHALL be absent; other behaviour identical.

Verification
REQ-031 reset release, en=1, defaults -> clk_out rises after 128 edges, period 256 cycles, tick every 128, rise_tick every 256.
REQ-032 div_load div_val=4 at count 50 of a 128 half-period -> current half-period completes at 128, following half-periods 4 cycles, div_cur=4 from that wrap.
REQ-033 en low for 10 cycles mid-period -> count/clk_out frozen, no ticks, wrap delayed exactly 10 cycles.
REQ-034 sync with div_load div_val=0 same cycle -> next cycle clk_out=0, count=0, div_cur=1, then clk_out toggles every cycle.
REQ-035 reset pulse asserted between edges at count 77 -> outputs 0 immediately, div_cur=128, pending load discarded.
REQ-036 CLK_DIV_QUAD_EN, N=8 -> clk_q period 16, toggles 4 cycles after each clk_out toggle; N=1 -> clk_q==clk_out.

Source files
------------

// File: rtl/clk_div_gen.sv
// Programmable clock divider: square wave of period 2*N, toggle/rise strobes, glitch-free divisor reload.
// Define CLK_DIV_QUAD_EN to add the quadrature output clk_q.
module clk_div_gen #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DIV_INIT = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             rise_tick,
`ifdef CLK_DIV_QUAD_EN
    output logic             clk_q,
`endif
    output logic [CNT_W-1:0] div_cur
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             rise_q, rise_d;

    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] apply_val;
    logic             apply;
    logic             wrap;

    // A divisor of zero is meaningless, so it is promoted to one.
    assign ld_val    = (div_val == '0) ? CNT_W'(1) : div_val;
    // A load in the same cycle as the apply point wins over an older pending value.
    assign apply     = div_load | pend_vld_q;
    assign apply_val = div_load ? ld_val : pend_q;
    assign wrap      = (cnt_q == (div_cur_q - CNT_W'(1)));

    always_comb begin
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        rise_d     = 1'b0;

        if (div_load) begin
            pend_d     = ld_val;
            pend_vld_d = 1'b1;
        end

        if (sync) begin
            cnt_d      = '0;
            clk_out_d  = 1'b0;
            pend_vld_d = 1'b0;
            if (apply) begin
                div_cur_d = apply_val;
            end
        end else if (en) begin
            if (wrap) begin
                cnt_d      = '0;
                clk_out_d  = ~clk_out_q;
                tick_d     = 1'b1;
                rise_d     = ~clk_out_q;
                pend_vld_d = 1'b0;
                if (apply) begin
                    div_cur_d = apply_val;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            div_cur_q  <= CNT_W'(DIV_INIT);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            rise_q     <= rise_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign rise_tick = rise_q;
    assign div_cur   = div_cur_q;

`ifdef CLK_DIV_QUAD_EN
    logic quad_q, quad_d;

    // Toggle on the edge where the count reaches N/2, i.e. N/2 cycles after clk_out.
    always_comb begin
        quad_d = quad_q;
        if (sync) begin
            quad_d = 1'b0;
        end else if (en) begin
            if (div_cur_q == CNT_W'(1)) begin
                quad_d = clk_out_d;
            end else if (!wrap && ((cnt_q + CNT_W'(1)) == (div_cur_q >> 1))) begin
                quad_d = ~quad_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quad_q <= 1'b0;
        end else begin
            quad_q <= quad_d;
        end
    end

    assign clk_q = quad_q;
`endif

endmodule
